// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder family (parallel adder and
// the bit-serial add/subtract unit).
//   state_e    : sequencing states of the bit-serial unit
//   RCA_W      : default operand width
//   cnt_width  : width of a counter that must hold values 0..w-1
package rca_pkg;

    localparam int RCA_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width for indices 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder, purely combinational.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial subtractor (optionally adder) built around one full-adder cell.
// Operands are taken over a valid/ready handshake, processed LSB first one bit
// per clock, and the result is offered over a second valid/ready handshake.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operands a/b presented
//   in_ready   : unit idle and able to accept operands
//   a, b       : minuend / subtrahend (addends in add mode), WIDTH bits
//   out_valid  : result presented
//   out_ready  : consumer takes the result
//   diff       : result modulo 2^WIDTH
//   flag       : borrow when subtracting (a < b unsigned), carry-out when adding
//   op_add     : only with SERIAL_ADDSUB_ADD_EN; 1 = add, 0 = subtract
//
// Build option: define SERIAL_ADDSUB_ADD_EN to add the op_add port and the
// add mode. Without it the unit always subtracts.
module serial_addsub
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             flag
`ifdef SERIAL_ADDSUB_ADD_EN
    ,
    input  logic             op_add
`endif
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e            state_r;
    state_e            state_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  res_r;
    logic [CW-1:0]     cnt_r;
    logic              carry_r;
    logic              add_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  diff_r;
    logic              flag_r;

    logic              add_sel_s;
    logic [WIDTH-1:0]  b_in_s;
    logic              accept_s;
    logic              release_s;
    logic              last_s;
    logic              sum_s;
    logic              cout_s;
    logic [WIDTH-1:0]  res_next_s;

`ifdef SERIAL_ADDSUB_ADD_EN
    assign add_sel_s = op_add;
`else
    assign add_sel_s = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
    assign b_in_s     = add_sel_s ? b : ~b;
    // in_ready_r is only ever high in IDLE, so it doubles as the state qualifier.
    assign accept_s   = in_valid & in_ready_r;
    assign release_s  = out_valid_r & out_ready;
    assign last_s     = (state_r == ST_RUN) && (cnt_r == LAST);
    // Sum bits enter at the MSB; after WIDTH shifts the first bit sits at bit 0.
    assign res_next_s = {sum_s, res_r[WIDTH-1:1]};

    fa_cell u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry_r),
        .s    (sum_s),
        .cout (cout_s)
    );

    // Next-state decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (release_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
        end
    end

    // Operand/result shifting, carry chain and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            add_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        b_r     <= b_in_s;
                        res_r   <= '0;
                        cnt_r   <= '0;
                        carry_r <= ~add_sel_s;
                        add_r   <= add_sel_s;
                    end
                end
                ST_RUN: begin
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    res_r   <= res_next_s;
                    carry_r <= cout_s;
                    cnt_r   <= cnt_r + CW'(1);
                end
                ST_DONE: begin
                    res_r <= res_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    // Result capture on the last bit; held untouched until the next operation ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_r <= '0;
            flag_r <= 1'b0;
        end else if (last_s) begin
            diff_r <= res_next_s;
            // Carry-out of a + ~b + 1 is 1 when no borrow occurred.
            flag_r <= add_r ? cout_s : ~cout_s;
        end else begin
            diff_r <= diff_r;
            flag_r <= flag_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign flag      = flag_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH = 3): directed operations with
// literal expectations plus a transaction-level reference model compared on
// every falling edge.
module tb_serial_addsub;

    localparam int W    = 3;
    localparam int MODV = 1 << W;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         op        = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic         flag;
    logic [W-1:0] diff;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .flag      (flag)
`ifdef SERIAL_ADDSUB_ADD_EN
        ,
        .op_add    (op)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int           m_left;
    logic         m_valid;
    logic         m_armed;
    logic [W-1:0] m_diff;
    logic         m_flag;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_valid <= 1'b0;
            m_armed <= 1'b0;
        end else begin
            m_armed <= 1'b1;
            if (m_valid) begin
                if (out_ready) m_valid <= 1'b0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_valid <= 1'b1;
            end else if (m_armed && in_valid) begin
                int av, bv, r;
                av = int'(a);
                bv = int'(b);
                m_left <= W;
                if (op) begin
                    r = av + bv;
                    m_flag <= (r >= MODV);
                end else begin
                    r = av - bv + MODV;
                    m_flag <= (av < bv);
                end
                m_diff <= W'(r % MODV);
            end
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mdl_in_ready", int'(in_ready), int'(m_armed && !m_valid && (m_left == 0)));
            chk("mdl_out_valid", int'(out_valid), int'(m_valid));
            if (m_valid) begin
                chk("mdl_diff", int'(diff), int'(m_diff));
                chk("mdl_flag", int'(flag), int'(m_flag));
            end
        end
    end

    // ---------------- directed operation ----------------
    // rdelay < 0: out_ready held high throughout; otherwise held low for
    // rdelay cycles after out_valid rises, then pulsed.
    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic top, input int ed, input int ef, input int rdelay);
        int n;
        int lat;
        @(negedge clk);
        a = ta; b = tb; op = top; in_valid = 1'b1;
        out_ready = (rdelay < 0);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({name, "_accept_timeout"}, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < W + 4) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, W);
        chk({name, "_diff"}, int'(diff), ed);
        chk({name, "_flag"}, int'(flag), ef);
        for (int i = 0; i < rdelay; i++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, int'(out_valid), 1);
            chk({name, "_hold_diff"}, int'(diff), ed);
            chk({name, "_hold_in_ready"}, int'(in_ready), 0);
        end
        if (rdelay >= 0) out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_post_valid"}, int'(out_valid), 0);
        chk({name, "_post_in_ready"}, int'(in_ready), 1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < W + 6) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk({name, "_valid_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset values while rst_n is low.
        #3;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_flag", int'(flag), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 1);

        // Basic subtraction patterns and boundaries.
        do_op("s5m3", 3'd5, 3'd3, 1'b0, 2, 0, -1);
        do_op("s2m5", 3'd2, 3'd5, 1'b0, 5, 1, 0);
        do_op("s7m7", 3'd7, 3'd7, 1'b0, 0, 0, 0);
        do_op("s0m1", 3'd0, 3'd1, 1'b0, 7, 1, 1);
        do_op("s4m0", 3'd4, 3'd0, 1'b0, 4, 0, 0);
        // Backpressure: result held stable for 5 cycles.
        do_op("bp6m1", 3'd6, 3'd1, 1'b0, 5, 0, 5);

        // Busy: in_valid held, operands change during RUN and DONE.
        @(negedge clk);
        a = 3'd5; b = 3'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        a = 3'd1; b = 3'd6;
        chk("busy_in_ready_run", int'(in_ready), 0);
        wait_valid("busy1");
        chk("busy1_diff", int'(diff), 2);
        chk("busy1_flag", int'(flag), 0);
        @(negedge clk);
        chk("busy_no_accept_done", int'(in_ready), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("busy_idle_valid", int'(out_valid), 0);
        chk("busy_idle_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("busy2");
        chk("busy2_diff", int'(diff), 3);
        chk("busy2_flag", int'(flag), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // in_valid pulsed during RUN and dropped: nothing latched afterwards.
        @(negedge clk);
        a = 3'd3; b = 3'd2; in_valid = 1'b1;
        @(negedge clk);
        a = 3'd7; b = 3'd0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("drop");
        chk("drop_diff", int'(diff), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (W + 2) @(negedge clk);
        chk("drop_no_second", int'(out_valid), 0);
        chk("drop_idle", int'(in_ready), 1);

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clk);
        a = 3'd6; b = 3'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rst_valid", int'(out_valid), 0);
        chk("abort_rst_ready", int'(in_ready), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_ready", int'(in_ready), 1);
        chk("abort_idle_valid", int'(out_valid), 0);
        repeat (W + 2) @(negedge clk);
        chk("abort_no_stale", int'(out_valid), 0);

        // Fresh operation after the abort.
        do_op("post_rst", 3'd3, 3'd6, 1'b0, 5, 1, 0);

`ifdef SERIAL_ADDSUB_ADD_EN
        do_op("add6p3", 3'd6, 3'd3, 1'b1, 1, 1, 0);
        do_op("sub6m3", 3'd6, 3'd3, 1'b0, 3, 0, 0);
        do_op("add2p3", 3'd2, 3'd3, 1'b1, 5, 0, 2);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
